// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: load FSM state enum, segment patterns (active-low, dp off),
// BCD-to-segment decode and BCD sanitising helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_WRITE = 2'd1,
    LD_ACK   = 2'd2,
    LD_WAIT  = 2'd3
  } load_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp bit is always 1 (off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Non-BCD codes (10-15) are stored as 0.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with synchronous load and ripple carry out.
// Latency: load/increment visible one cycle later; carry is combinational.
// Backpressure: none; load has priority over inc.
// Ports: clk, rst (async active-low), load, load_val[3:0], inc,
//        q[3:0] current digit, carry = inc && q==9.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_display_ctrl.sv
// Four-digit BCD counter with handshake digit load and multiplexed 7-seg scan.
// Latency: count/ovf update on the tick edge; an/disp lag the scan index by 1 cycle.
// Backpressure: load_req is held until load_ack; one request = one load.
// Ports: clk, rst (async active-low), en, load_req, load_sel[1:0],
//        load_data[3:0] -> load_ack, count[15:0], ovf, an[3:0], disp[7:0].
module bcd_display_ctrl
  import bcd_pkg::*;
#(
  parameter int COUNT_DIV = 8,
  parameter int SCAN_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_req,
  input  logic [1:0]  load_sel,
  input  logic [3:0]  load_data,
  output logic        load_ack,
  output logic [15:0] count,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [7:0]  disp
);

  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Count prescaler: free-running, independent of en and load activity.
  logic [CW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == CW'(COUNT_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + CW'(1);

  // Load handshake FSM.
  load_state_e state_q, state_d;
  logic        write;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (load_req) state_d = LD_WRITE;
      LD_WRITE: state_d = LD_ACK;
      LD_ACK:   state_d = LD_WAIT;
      LD_WAIT:  if (!load_req) state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  assign write    = (state_q == LD_WRITE);
  assign load_ack = (state_q == LD_ACK);

  // Digit chain. A load cycle swallows a coincident tick for every digit,
  // so the ones increment is gated by write and no carry can ripple.
  logic [3:0] dig [4];
  logic [3:0] carry;
  logic [4:0] inc;
  logic [3:0] load_val;

  assign load_val = bcd_sanitize(load_data);
  assign inc      = {carry, tick & en & ~write};

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (write && (load_sel == 2'(g))),
      .load_val (load_val),
      .inc      (inc[g]),
      .q        (dig[g]),
      .carry    (carry[g])
    );
  end

  assign count = {dig[3], dig[2], dig[1], dig[0]};

  // Carry out of the thousands digit only happens on 9999 -> 0000.
  logic ovf_q, ovf_d;
  assign ovf_d = inc[4];
  assign ovf   = ovf_q;

  // Display scan.
  logic [SW-1:0] scan_q, scan_d;
  logic          scan_wrap;
  logic [1:0]    idx_q, idx_d;

  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
  assign scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
  assign idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;

  // an and disp are registered from the same index so they never disagree.
  logic [3:0] an_q, an_d;
  logic [7:0] disp_q, disp_d;

  assign an_d   = ~(4'b0001 << idx_q);
  assign disp_d = bcd_to_seg(dig[idx_q]);
  assign an     = an_q;
  assign disp   = disp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      state_q <= LD_IDLE;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      disp_q  <= SEG_0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      disp_q  <= disp_d;
    end
  end

endmodule
